fb_swap_sequencer: RTL and testbench
====================================

// Module: fb_swap_sequencer
// PURPOSE
//  Display-side double-buffer swap controller, directly upstream of the DVI scanout block.
//  Accepts framebuffer swap commands (address + vsync flag) from the renderer via valid/ready.
//  Optionally aligns each swap to a frame_start pulse from display timing.
//  Drives the scanout swap/swapped four-phase handshake and tracks the displayed buffer.
// PARAMETERS
//  FB_ADDR_DEFAULT  32'h01E00000  front_addr value after reset
//  ADDR_ALIGN_BITS  12            low bits of s_swap_addr that must be zero
//  TIMEOUT_CYCLES   2000000       watchdog limit (cycles) for each handshake phase; 24-bit counter
// PORTS
//  aclk             in   1   clock
//  resetn           in   1   synchronous active-low reset
//  s_swap_valid     in   1   swap command valid
//  s_swap_ready     out  1   swap command accepted when valid&&ready
//  s_swap_addr      in   32  new framebuffer base address
//  s_swap_vsync     in   1   1: wait for frame_start before swapping
//  frame_start      in   1   single-cycle pulse at start of vertical blank
//  dvi_swap         out  1   swap request to scanout
//  dvi_fb_addr      out  32  address presented with dvi_swap
//  dvi_enable_vsync out  1   latched vsync flag of the active command
//  dvi_swapped      in   1   scanout ack: 1 idle, 0 swap taken
//  front_addr       out  32  currently displayed framebuffer address
//  swap_done        out  1   1-cycle pulse when a swap completes
//  swap_error       out  1   1-cycle pulse on misaligned address or timeout
//  swap_count       out  16  completed swaps, wraps 16'hFFFF->0
// BEHAVIOUR
//  Reset: state IDLE; dvi_swap=0, dvi_fb_addr=FB_ADDR_DEFAULT, dvi_enable_vsync=0,
//   front_addr=FB_ADDR_DEFAULT, swap_done=0, swap_error=0, swap_count=0, timer=0.
//   Reset mid-handshake drops dvi_swap the next cycle, with no done/error pulse.
//  All outputs registered except s_swap_ready = (state==IDLE) && dvi_swapped.
//  States: IDLE, WAIT_FRAME, REQ, RELEASE.
//  IDLE: on accept, latch addr->dvi_fb_addr and vsync->dvi_enable_vsync.
//   - addr[ADDR_ALIGN_BITS-1:0]!=0: discard; swap_error pulses next cycle; stay IDLE.
//   - else if vsync: -> WAIT_FRAME; else -> REQ (dvi_swap=1 the cycle after accept).
//  WAIT_FRAME: only frame_start seen in cycles after accept counts; a pulse in the accept
//   cycle itself is ignored. On frame_start -> REQ. No timeout here (display may be paused).
//  REQ: dvi_swap=1; timer counts each cycle. dvi_swapped==0 -> RELEASE, dvi_swap=0, timer=0.
//   timer==TIMEOUT_CYCLES-1 without ack -> dvi_swap=0, swap_error pulse, IDLE; front_addr unchanged.
//  RELEASE: dvi_swap=0; wait dvi_swapped==1 -> IDLE; same cycle front_addr<=dvi_fb_addr,
//   swap_done pulse, swap_count+1. Timeout -> swap_error pulse, IDLE, front_addr unchanged;
//   s_swap_ready stays low until dvi_swapped returns 1.
//  A swap_done or swap_error pulse comes one cycle after its triggering event.
//  Only one command is in flight; no buffering. s_swap_addr/vsync are sampled only at accept.
//  Both handshake edges may occur on consecutive cycles; min REQ->IDLE path is 2 cycles.
//  dvi_fb_addr holds its last value in IDLE; the timer clears on every state entry.
// TESTING
//  Reset, then hold s_swap_valid=0 -> s_swap_ready=1, front_addr=32'h01E00000,
//   swap_count=0, dvi_swap=0.
//  Addr 32'h01C00000, vsync=0; model acks 1 cycle after dvi_swap and re-idles 1 cycle later
//   -> dvi_swap high 1 cycle after accept; swap_done=1; front_addr=32'h01C00000; count=1.
//  Addr 32'h01A00000, vsync=1, frame_start 50 cycles later -> dvi_swap stays 0 until the
//   cycle after frame_start; dvi_enable_vsync=1; frame_start in accept cycle is ignored.
//  Addr 32'h01C00010 -> swap_error pulse; no dvi_swap; front_addr and count unchanged.
//  TIMEOUT_CYCLES=16; model never acks -> dvi_swap drops after 16 cycles; swap_error=1;
//   s_swap_ready=1 again; front_addr unchanged.
//  Issue 65536 back-to-back vsync=0 swaps -> swap_count wraps to 0; assert resetn=0
//   while dvi_swap=1 -> dvi_swap=0 next cycle.

Source files
------------

// File: rtl/fb_swap_sequencer.sv
// fb_swap_sequencer: double-buffer swap controller driving the scanout swap/swapped handshake,
// optionally aligned to frame_start, with per-phase watchdog and displayed-buffer tracking.
module fb_swap_sequencer #(
  parameter logic [31:0] FB_ADDR_DEFAULT = 32'h01E00000,
  parameter int ADDR_ALIGN_BITS = 12,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic        aclk,
  input  logic        resetn,
  input  logic        s_swap_valid,
  output logic        s_swap_ready,
  input  logic [31:0] s_swap_addr,
  input  logic        s_swap_vsync,
  input  logic        frame_start,
  output logic        dvi_swap,
  output logic [31:0] dvi_fb_addr,
  output logic        dvi_enable_vsync,
  input  logic        dvi_swapped,
  output logic [31:0] front_addr,
  output logic        swap_done,
  output logic        swap_error,
  output logic [15:0] swap_count
);
  typedef enum logic [1:0] {IDLE, WAIT_FRAME, REQ, RELEASE} state_t;
  localparam logic [23:0] TMAX = 24'(TIMEOUT_CYCLES - 1);
  state_t state;
  logic [23:0] timer;
  logic accept, aligned, timeout;
  assign s_swap_ready = (state == IDLE) && dvi_swapped;
  assign accept = s_swap_valid && s_swap_ready;
  assign aligned = s_swap_addr[ADDR_ALIGN_BITS-1:0] == '0;
  assign timeout = timer == TMAX;
  // timer defaults to zero so it clears on every state entry and only runs in REQ/RELEASE
  always_ff @(posedge aclk)
    if (!resetn) begin
      state <= IDLE;
      timer <= '0;
      dvi_swap <= 1'b0;
      dvi_fb_addr <= FB_ADDR_DEFAULT;
      dvi_enable_vsync <= 1'b0;
      front_addr <= FB_ADDR_DEFAULT;
      swap_done <= 1'b0;
      swap_error <= 1'b0;
      swap_count <= '0;
    end else begin
      swap_done <= 1'b0;
      swap_error <= 1'b0;
      timer <= '0;
      unique case (state)
        IDLE: if (accept) begin
          dvi_fb_addr <= s_swap_addr;
          dvi_enable_vsync <= s_swap_vsync;
          if (!aligned) swap_error <= 1'b1;
          else if (s_swap_vsync) state <= WAIT_FRAME;
          else begin
            state <= REQ;
            dvi_swap <= 1'b1;
          end
        end
        WAIT_FRAME: if (frame_start) begin
          state <= REQ;
          dvi_swap <= 1'b1;
        end
        REQ: if (!dvi_swapped) begin
          state <= RELEASE;
          dvi_swap <= 1'b0;
        end else if (timeout) begin
          state <= IDLE;
          dvi_swap <= 1'b0;
          swap_error <= 1'b1;
        end else timer <= timer + 24'd1;
        RELEASE: if (dvi_swapped) begin
          state <= IDLE;
          front_addr <= dvi_fb_addr;
          swap_done <= 1'b1;
          swap_count <= swap_count + 16'd1;
        end else if (timeout) begin
          state <= IDLE;
          swap_error <= 1'b1;
        end else timer <= timer + 24'd1;
      endcase
    end
endmodule

// File: tb/tb_fb_swap_sequencer.sv
// tb_fb_swap_sequencer: table vectors, directed corner sequences and random transactions
// checked against a transaction-level timeline model of the swap sequencer.
module tb_fb_swap_sequencer;
  localparam int TO = 16;
  localparam logic [31:0] DEF = 32'h01E00000;
  logic aclk = 1'b0, resetn = 1'b0, s_swap_valid = 1'b0, s_swap_vsync = 1'b0;
  logic frame_start = 1'b0, dvi_swapped = 1'b1;
  logic [31:0] s_swap_addr = '0;
  logic s_swap_ready, dvi_swap, dvi_enable_vsync, swap_done, swap_error;
  logic [31:0] dvi_fb_addr, front_addr;
  logic [15:0] swap_count;
  int errors = 0, checks = 0;
  logic [31:0] m_front = DEF;
  logic [15:0] m_count = '0;
  typedef struct {
    logic [31:0] a;
    logic v;
    int fs, ack, rel;
    bit fa;
    int e_rise, e_hi, e_done, e_err;
  } vec_t;
  vec_t vecs[10];
  always #5 aclk = ~aclk;
  fb_swap_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
    .aclk(aclk), .resetn(resetn), .s_swap_valid(s_swap_valid), .s_swap_ready(s_swap_ready),
    .s_swap_addr(s_swap_addr), .s_swap_vsync(s_swap_vsync), .frame_start(frame_start),
    .dvi_swap(dvi_swap), .dvi_fb_addr(dvi_fb_addr), .dvi_enable_vsync(dvi_enable_vsync),
    .dvi_swapped(dvi_swapped), .front_addr(front_addr), .swap_done(swap_done),
    .swap_error(swap_error), .swap_count(swap_count)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step;
    @(posedge aclk);
    #1;
  endtask
  // Timeline model: when dvi_swap should rise, how long it stays high, and the outcome.
  function automatic void predict(input logic [31:0] a, input logic v, input int fs, input int ack,
                                  input int rel, output int rise, output int hi, output int nd,
                                  output int ne);
    rise = -1; hi = 0; nd = 0; ne = 0;
    if (a[11:0] != 0) ne = 1;
    else begin
      rise = v ? fs + 1 : 1;
      if (ack < 0 || ack >= TO) begin hi = TO; ne = 1; end
      else begin
        hi = ack + 1;
        if (rel < 0 || rel >= TO) ne = 1; else nd = 1;
      end
    end
  endfunction
  // Runs one command; the scanout side drops swapped ack cycles after dvi_swap rises and
  // raises it rel cycles into the release phase (negative = never).
  task automatic txn(input logic [31:0] a, input logic v, input int fs, input bit fa,
                     input int ack, input int rel,
                     output int rise, output int hi, output int nd, output int ne);
    int w, drop_c, rel_c;
    rise = -1; hi = 0; nd = 0; ne = 0; drop_c = -1; rel_c = -1; w = 0;
    while (!s_swap_ready && w < 100) begin step; w++; end
    chk("ready_before_accept", 32'(s_swap_ready), 1);
    s_swap_valid = 1'b1; s_swap_addr = a; s_swap_vsync = v; frame_start = fa;
    step;
    s_swap_valid = 1'b0; s_swap_addr = $urandom; s_swap_vsync = 1'($urandom); frame_start = 1'b0;
    for (int c = 1; c < 200 && nd + ne == 0; c++) begin
      if (dvi_swap && rise < 0) rise = c;
      hi += int'(dvi_swap);
      nd += int'(swap_done);
      ne += int'(swap_error);
      frame_start = (c == fs);
      if (rise >= 0 && drop_c < 0 && ack >= 0 && c == rise + ack) begin
        dvi_swapped = 1'b0;
        drop_c = c;
      end
      if (drop_c >= 0 && c > drop_c && rel_c < 0) rel_c = c;
      if (rel_c >= 0 && rel >= 0 && c == rel_c + rel) dvi_swapped = 1'b1;
      step;
    end
    frame_start = 1'b0;
    dvi_swapped = 1'b1;
    repeat (3) begin
      step;
      nd += int'(swap_done);
      ne += int'(swap_error);
    end
  endtask
  task automatic run(input string tag, input logic [31:0] a, input logic v, input int fs,
                     input bit fa, input int ack, input int rel, input bit use_tab,
                     input int t_rise, input int t_hi, input int t_done, input int t_err);
    int rise, hi, nd, ne, p_rise, p_hi, p_nd, p_ne;
    predict(a, v, fs, ack, rel, p_rise, p_hi, p_nd, p_ne);
    if (use_tab) begin p_rise = t_rise; p_hi = t_hi; p_nd = t_done; p_ne = t_err; end
    txn(a, v, fs, fa, ack, rel, rise, hi, nd, ne);
    if (nd > 0 && p_nd > 0) begin m_front = a; m_count++; end
    chk({tag, "_rise"}, 32'(rise), 32'(p_rise));
    chk({tag, "_hi"}, 32'(hi), 32'(p_hi));
    chk({tag, "_done"}, 32'(nd), 32'(p_nd));
    chk({tag, "_err"}, 32'(ne), 32'(p_ne));
    chk({tag, "_front"}, front_addr, m_front);
    chk({tag, "_count"}, 32'(swap_count), 32'(m_count));
    chk({tag, "_fbaddr"}, dvi_fb_addr, a);
    chk({tag, "_vsync"}, 32'(dvi_enable_vsync), 32'(v));
    chk({tag, "_swap_low"}, 32'(dvi_swap), 0);
  endtask
  initial begin
    int n, dn, w;
    vecs[0] = '{32'h01C00000, 1'b0, 0, 1, 1, 1'b0, 1, 2, 1, 0};
    vecs[1] = '{32'h01A00000, 1'b1, 50, 1, 1, 1'b1, 51, 2, 1, 0};
    vecs[2] = '{32'h01C00010, 1'b0, 0, 0, 0, 1'b0, -1, 0, 0, 1};
    vecs[3] = '{32'h01C00010, 1'b1, 5, 0, 0, 1'b0, -1, 0, 0, 1};
    vecs[4] = '{32'h01800000, 1'b0, 0, -1, 0, 1'b0, 1, 16, 0, 1};
    vecs[5] = '{32'h01800000, 1'b0, 0, 15, 0, 1'b0, 1, 16, 1, 0};
    vecs[6] = '{32'h01800000, 1'b0, 0, 0, 15, 1'b0, 1, 1, 1, 0};
    vecs[7] = '{32'h01600000, 1'b0, 0, 0, -1, 1'b0, 1, 1, 0, 1};
    vecs[8] = '{32'h01400000, 1'b1, 1, 0, 0, 1'b0, 2, 1, 1, 0};
    vecs[9] = '{32'hFFFFF000, 1'b0, 0, 2, 3, 1'b0, 1, 3, 1, 0};
    repeat (3) step;
    resetn = 1'b1;
    step;
    chk("rst_ready", 32'(s_swap_ready), 1);
    chk("rst_front", front_addr, DEF);
    chk("rst_count", 32'(swap_count), 0);
    chk("rst_swap", 32'(dvi_swap), 0);
    chk("rst_fbaddr", dvi_fb_addr, DEF);
    chk("rst_vsync", 32'(dvi_enable_vsync), 0);
    chk("rst_pulses", {30'd0, swap_done, swap_error}, 0);
    foreach (vecs[i])
      run($sformatf("vec%0d", i), vecs[i].a, vecs[i].v, vecs[i].fs, vecs[i].fa, vecs[i].ack,
          vecs[i].rel, 1'b1, vecs[i].e_rise, vecs[i].e_hi, vecs[i].e_done, vecs[i].e_err);
    // Release-phase timeout: ready must stay low until swapped comes back.
    s_swap_valid = 1'b1; s_swap_addr = 32'h01200000; s_swap_vsync = 1'b0;
    step;
    s_swap_valid = 1'b0;
    dvi_swapped = 1'b0;
    w = 0;
    while (!swap_error && w < 40) begin step; w++; end
    chk("reltmo_error", 32'(swap_error), 1);
    chk("reltmo_ready_low", 32'(s_swap_ready), 0);
    chk("reltmo_front", front_addr, m_front);
    step;
    chk("reltmo_ready_still_low", 32'(s_swap_ready), 0);
    dvi_swapped = 1'b1;
    #1;
    chk("reltmo_ready_back", 32'(s_swap_ready), 1);
    step;
    for (int i = 0; i < 150; i++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(4) != 0) a[11:0] = '0;
      run("rnd", a, 1'($urandom), int'($urandom_range(20, 1)), 1'($urandom),
          $urandom_range(5) == 0 ? -1 : int'($urandom_range(5)),
          $urandom_range(5) == 0 ? -1 : int'($urandom_range(5)), 1'b0, 0, 0, 0, 0);
    end
    // Back-to-back swaps until the completed-swap counter wraps to zero.
    n = 65536 - int'(m_count);
    dn = 0;
    s_swap_valid = 1'b1; s_swap_addr = 32'h01C00000; s_swap_vsync = 1'b0;
    for (int i = 0; i < n; i++) begin
      step;
      dvi_swapped = 1'b0;
      step;
      dvi_swapped = 1'b1;
      step;
      dn += int'(swap_done);
      if (i == n - 2) chk("wrap_ffff", 32'(swap_count), 32'h0000FFFF);
    end
    s_swap_valid = 1'b0;
    m_count = m_count + 16'(n);
    m_front = 32'h01C00000;
    chk("wrap_zero", 32'(swap_count), 0);
    chk("wrap_model", 32'(swap_count), 32'(m_count));
    chk("wrap_dones", 32'(dn), 32'(n));
    chk("wrap_front", front_addr, m_front);
    step;
    // Reset asserted mid-handshake.
    s_swap_valid = 1'b1; s_swap_addr = 32'h01000000; s_swap_vsync = 1'b0;
    step;
    s_swap_valid = 1'b0;
    chk("midrst_swap_high", 32'(dvi_swap), 1);
    resetn = 1'b0;
    step;
    chk("midrst_swap_low", 32'(dvi_swap), 0);
    chk("midrst_pulses", {30'd0, swap_done, swap_error}, 0);
    chk("midrst_front", front_addr, DEF);
    chk("midrst_count", 32'(swap_count), 0);
    resetn = 1'b1;
    m_front = DEF;
    m_count = '0;
    step;
    run("post_rst", 32'h01C00000, 1'b0, 0, 1'b0, 0, 0, 1'b0, 0, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
